// File: rtl/glm_line_reader.sv
// Sequential cache-line read engine: issues CCI-P channel-0 reads for a range of lines
// under a credit limit and forwards each read response downstream tagged with its line index.
module glm_line_reader #(
    parameter int ADDR_W          = 42,
    parameter int LINES_W         = 16,
    parameter int MAX_OUTSTANDING = 64,
    parameter int DATA_W          = 512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LINES_W-1:0] num_lines,
    output logic               busy,
    output logic               done,
    output logic               c0_tx_valid,
    output logic [ADDR_W-1:0]  c0_tx_addr,
    output logic [15:0]        c0_tx_mdata,
    input  logic               c0_tx_almfull,
    input  logic               c0_rx_valid,
    input  logic               c0_rx_is_rdrsp,
    input  logic [15:0]        c0_rx_mdata,
    input  logic [DATA_W-1:0]  c0_rx_data,
    output logic               out_valid,
    output logic [LINES_W-1:0] out_idx,
    output logic [DATA_W-1:0]  out_data
);
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [LINES_W-1:0]   num_q, num_d;
    logic [LINES_W-1:0]   issued_q, issued_d;
    logic [LINES_W-1:0]   received_q, received_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0]    tx_addr_q, tx_addr_d;
    logic [15:0]          tx_mdata_q, tx_mdata_d;
    logic                 out_valid_q, out_valid_d;
    logic [LINES_W-1:0]   out_idx_q, out_idx_d;
    logic [DATA_W-1:0]    out_data_q, out_data_d;
    logic                 issue;
    logic                 accept;

    assign busy   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done   = (state_q == S_DONE);
    assign issue  = (state_q == S_ISSUE) && !c0_tx_almfull &&
                    (outstanding_q < MAX_CNT) && (issued_q < num_q);
    assign accept = busy && c0_rx_valid && c0_rx_is_rdrsp;

    always_comb begin
        // NOTE: every _d signal gets its hold value first, so no branch can infer a latch.
        state_d       = state_q;
        base_d        = base_q;
        num_d         = num_q;
        issued_d      = issue  ? issued_q + LINES_W'(1)   : issued_q;
        received_d    = accept ? received_q + LINES_W'(1) : received_q;
        outstanding_d = outstanding_q;
        tx_valid_d    = issue;
        tx_addr_d     = issue ? base_q + ADDR_W'(issued_q) : tx_addr_q;
        tx_mdata_d    = issue ? 16'(issued_q) : tx_mdata_q;
        out_valid_d   = accept;
        out_idx_d     = accept ? c0_rx_mdata[LINES_W-1:0] : out_idx_q;
        out_data_d    = accept ? c0_rx_data : out_data_q;

        // Issue and response in the same cycle cancel; a stray response never underflows.
        case ({issue, accept})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d        = base_addr;
                    num_d         = num_lines;
                    issued_d      = '0;
                    received_d    = '0;
                    outstanding_d = '0;
                    state_d       = (num_lines == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issued_d == num_q) state_d = (received_d == num_q) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (received_d == num_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            num_q         <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            outstanding_q <= '0;
            tx_valid_q    <= 1'b0;
            tx_addr_q     <= '0;
            tx_mdata_q    <= '0;
            out_valid_q   <= 1'b0;
            out_idx_q     <= '0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            num_q         <= num_d;
            issued_q      <= issued_d;
            received_q    <= received_d;
            outstanding_q <= outstanding_d;
            tx_valid_q    <= tx_valid_d;
            tx_addr_q     <= tx_addr_d;
            tx_mdata_q    <= tx_mdata_d;
            out_valid_q   <= out_valid_d;
            out_idx_q     <= out_idx_d;
            out_data_q    <= out_data_d;
        end
    end

    assign c0_tx_valid = tx_valid_q;
    assign c0_tx_addr  = tx_addr_q;
    assign c0_tx_mdata = tx_mdata_q;
    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign out_data    = out_data_q;

endmodule

// File: tb/tb_glm_line_reader.sv
// Directed bench for glm_line_reader: in-order, out-of-order, credit limit, almfull,
// zero-length, ignored start and mid-transfer reset, all against hand-derived expectations.
module tb_glm_line_reader;
    localparam int ADDR_W  = 42;
    localparam int LINES_W = 16;
    localparam int MAX_OUT = 8;
    localparam int DATA_W  = 512;

    logic               clk = 1'b0;
    logic               reset, start;
    logic [ADDR_W-1:0]  base_addr;
    logic [LINES_W-1:0] num_lines;
    logic               busy, done;
    logic               c0_tx_valid;
    logic [ADDR_W-1:0]  c0_tx_addr;
    logic [15:0]        c0_tx_mdata;
    logic               c0_tx_almfull;
    logic               c0_rx_valid, c0_rx_is_rdrsp;
    logic [15:0]        c0_rx_mdata;
    logic [DATA_W-1:0]  c0_rx_data;
    logic               out_valid;
    logic [LINES_W-1:0] out_idx;
    logic [DATA_W-1:0]  out_data;

    glm_line_reader #(
        .ADDR_W(ADDR_W), .LINES_W(LINES_W), .MAX_OUTSTANDING(MAX_OUT), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_lines(num_lines),
        .busy(busy), .done(done), .c0_tx_valid(c0_tx_valid), .c0_tx_addr(c0_tx_addr),
        .c0_tx_mdata(c0_tx_mdata), .c0_tx_almfull(c0_tx_almfull), .c0_rx_valid(c0_rx_valid),
        .c0_rx_is_rdrsp(c0_rx_is_rdrsp), .c0_rx_mdata(c0_rx_mdata), .c0_rx_data(c0_rx_data),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: samples on the falling edge, well away from the active edge.
    logic [ADDR_W-1:0]  req_addr_q[$];
    logic [15:0]        req_mdata_q[$];
    int                 req_cyc_q[$];
    logic [LINES_W-1:0] out_idx_hist[$];
    logic [DATA_W-1:0]  out_data_hist[$];
    int                 out_cyc_hist[$];
    int                 done_cnt = 0;
    int                 done_cyc = -1;
    logic               done_with_out = 1'b0;

    always @(negedge clk) begin
        if (c0_tx_valid) begin
            req_addr_q.push_back(c0_tx_addr);
            req_mdata_q.push_back(c0_tx_mdata);
            req_cyc_q.push_back(cyc);
        end
        if (out_valid) begin
            out_idx_hist.push_back(out_idx);
            out_data_hist.push_back(out_data);
            out_cyc_hist.push_back(cyc);
        end
        if (done) begin
            done_cnt      <= done_cnt + 1;
            done_cyc      <= cyc;
            done_with_out <= out_valid;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_tags[$];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] line_data(input logic [15:0] tag);
        return {16{16'hC0DE, tag}};
    endfunction

    task automatic start_xfer(input logic [ADDR_W-1:0] base, input logic [LINES_W-1:0] num);
        start = 1'b1; base_addr = base; num_lines = num;
        tick();
        start = 1'b0;
    endtask

    task automatic send_rsp(input logic [15:0] tag, input logic is_rd);
        c0_rx_valid = 1'b1; c0_rx_is_rdrsp = is_rd; c0_rx_mdata = tag; c0_rx_data = line_data(tag);
        tick();
        c0_rx_valid = 1'b0; c0_rx_is_rdrsp = 1'b0;
    endtask

    task automatic wait_reqs(input string tag, input int rb, input int n, input int budget);
        for (int i = 0; i < budget && (req_addr_q.size() - rb) < n; i++) tick();
        check(tag, ((req_addr_q.size() - rb) >= n), 1);
    endtask

    task automatic wait_done(input string tag, input int db, input int budget);
        for (int i = 0; i < budget && done_cnt == db; i++) tick();
        check(tag, done_cnt - db, 1);
    endtask

    task automatic respond_in_order(input string tag, input int rb, input int num);
        for (int t = 0; t < num; t++) begin
            wait_reqs(tag, rb, t + 1, 40);
            send_rsp(16'(t), 1'b1);
        end
    endtask

    task automatic check_reqs(input string tag, input int rb, input logic [ADDR_W-1:0] base, input int num);
        check({tag, "_req_count"}, req_addr_q.size() - rb, num);
        for (int i = 0; i < num && (rb + i) < req_addr_q.size(); i++) begin
            check({tag, "_req_addr"}, req_addr_q[rb + i], base + ADDR_W'(i));
            check({tag, "_req_mdata"}, req_mdata_q[rb + i], i);
        end
    endtask

    task automatic check_outs(input string tag, input int ob);
        check({tag, "_out_count"}, out_idx_hist.size() - ob, exp_tags.size());
        for (int i = 0; i < exp_tags.size() && (ob + i) < out_idx_hist.size(); i++) begin
            check({tag, "_out_idx"}, out_idx_hist[ob + i], exp_tags[i]);
            check({tag, "_out_data"}, out_data_hist[ob + i], line_data(exp_tags[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_tx_valid"}, c0_tx_valid, 0);
        check({tag, "_tx_addr"}, c0_tx_addr, 0);
        check({tag, "_tx_mdata"}, c0_tx_mdata, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, ob, db, s, alm_cyc, n_at, n_after, n_pre;

        reset = 1'b0; start = 1'b0; base_addr = '0; num_lines = '0; c0_tx_almfull = 1'b0;
        c0_rx_valid = 1'b0; c0_rx_is_rdrsp = 1'b0; c0_rx_mdata = '0; c0_rx_data = '0;
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b1;
        tick();

        // Basic in-order transfer, 5-cycle latency, with a write ack that must be ignored.
        rb = req_addr_q.size(); ob = out_idx_hist.size(); db = done_cnt; s = cyc;
        start_xfer(42'h1000, 4);
        check("basic_busy", busy, 1);
        while (cyc < s + 6) tick();
        send_rsp(16'd1, 1'b0);
        for (int t = 0; t < 4; t++) send_rsp(16'(t), 1'b1);
        wait_done("basic_done", db, 20);
        check_reqs("basic", rb, 42'h1000, 4);
        for (int i = 0; i < 4 && (rb + i) < req_cyc_q.size(); i++)
            check("basic_req_cycle", req_cyc_q[rb + i], s + 2 + i);
        exp_tags = '{16'd0, 16'd1, 16'd2, 16'd3};
        check_outs("basic", ob);
        if (ob < out_cyc_hist.size()) check("basic_first_out_cycle", out_cyc_hist[ob], s + 8);
        check("basic_done_cycle", done_cyc, s + 11);
        check("basic_done_with_out", done_with_out, 1);
        tick();
        check("basic_busy_after", busy, 0);
        check("basic_done_after", done, 0);

        // Out-of-order responses.
        rb = req_addr_q.size(); ob = out_idx_hist.size(); db = done_cnt;
        start_xfer(42'h2000, 4);
        wait_reqs("ooo_reqs", rb, 4, 20);
        exp_tags = '{16'd2, 16'd0, 16'd3, 16'd1};
        for (int i = 0; i < 4; i++) send_rsp(exp_tags[i], 1'b1);
        wait_done("ooo_done", db, 20);
        check_reqs("ooo", rb, 42'h2000, 4);
        check_outs("ooo", ob);
        check("ooo_done_with_out", done_with_out, 1);
        tick();

        // Credit limit of 8 with responses withheld for 10 cycles.
        rb = req_addr_q.size(); ob = out_idx_hist.size(); db = done_cnt;
        start_xfer(42'h3000, 20);
        repeat (9) tick();
        check("credit_cap", req_addr_q.size() - rb, 8);
        check("credit_stall_valid", c0_tx_valid, 0);
        send_rsp(16'd0, 1'b1);
        repeat (3) tick();
        check("credit_release_1", req_addr_q.size() - rb, 9);
        check("credit_stall_valid_1", c0_tx_valid, 0);
        send_rsp(16'd1, 1'b1);
        repeat (3) tick();
        check("credit_release_2", req_addr_q.size() - rb, 10);
        send_rsp(16'd2, 1'b1);
        send_rsp(16'd3, 1'b1);
        repeat (3) tick();
        check("credit_same_cycle", req_addr_q.size() - rb, 12);
        for (int t = 4; t < 20; t++) begin
            wait_reqs("credit_reqs", rb, t + 1, 40);
            send_rsp(16'(t), 1'b1);
        end
        wait_done("credit_done", db, 20);
        check_reqs("credit", rb, 42'h3000, 20);
        check("credit_out_count", out_idx_hist.size() - ob, 20);
        tick();

        // Almfull throttle held for 6 cycles after two requests.
        rb = req_addr_q.size(); db = done_cnt;
        start_xfer(42'h4000, 6);
        tick(); tick();
        c0_tx_almfull = 1'b1; alm_cyc = cyc;
        repeat (6) tick();
        c0_tx_almfull = 1'b0;
        n_pre = 0; n_at = 0; n_after = 0;
        for (int i = rb; i < req_cyc_q.size(); i++) begin
            if (req_cyc_q[i] <= alm_cyc) n_pre++;
            else if (req_cyc_q[i] == alm_cyc + 1) n_at++;
            else n_after++;
        end
        check("alm_pre", n_pre, 2);
        check("alm_at_most_one", (n_at <= 1), 1);
        check("alm_none_while_full", n_after, 0);
        respond_in_order("alm_reqs", rb, 6);
        wait_done("alm_done", db, 20);
        check_reqs("alm", rb, 42'h4000, 6);
        tick();

        // Zero-length transfer.
        rb = req_addr_q.size(); db = done_cnt;
        start_xfer(42'h5555, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_tx_valid", c0_tx_valid, 0);
        tick();
        check("zero_done_pulse", done, 0);
        repeat (3) tick();
        check("zero_req_count", req_addr_q.size() - rb, 0);
        check("zero_done_count", done_cnt - db, 1);

        // Start pulsed while busy must not disturb the running transfer.
        rb = req_addr_q.size(); ob = out_idx_hist.size(); db = done_cnt;
        start_xfer(42'h5000, 3);
        tick();
        start = 1'b1; base_addr = 42'h9000; num_lines = 16'd7;
        tick();
        start = 1'b0;
        respond_in_order("ign_reqs", rb, 3);
        wait_done("ign_done", db, 20);
        repeat (4) tick();
        check_reqs("ign", rb, 42'h5000, 3);
        check("ign_out_count", out_idx_hist.size() - ob, 3);
        check("ign_busy_after", busy, 0);

        // Reset after 3 of 10 requests, stale responses in IDLE, then a fresh transfer.
        rb = req_addr_q.size();
        start_xfer(42'h6000, 10);
        wait_reqs("rst_reqs", rb, 3, 20);
        reset = 1'b0;
        tick(); tick();
        check_reset_outputs("rst");
        check("rst_req_count", req_addr_q.size() - rb, 3);
        reset = 1'b1;
        ob = out_idx_hist.size();
        for (int t = 0; t < 3; t++) send_rsp(16'(t), 1'b1);
        repeat (3) tick();
        check("rst_stale_out", out_idx_hist.size() - ob, 0);
        check("rst_stale_busy", busy, 0);
        rb = req_addr_q.size(); ob = out_idx_hist.size(); db = done_cnt;
        start_xfer(42'h7000, 2);
        respond_in_order("post_rst_reqs", rb, 2);
        wait_done("post_rst_done", db, 20);
        check_reqs("post_rst", rb, 42'h7000, 2);
        exp_tags = '{16'd0, 16'd1};
        check_outs("post_rst", ob);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/glm_line_reader.md
Name: glm_line_reader

Overview:
- Sequential cache-line read engine inside glm_top.
- Drives the CCI-P channel-0 read request path toward app_afu, which marks every read virtual, VC-mapped and ordered before passing it to MPF.
- Consumes the matching channel-0 read responses and hands each line downstream with its line index. Responses may arrive out of order; the consumer writes them into its buffer by index.
- Bounds in-flight reads with a credit counter and throttles on c0TxAlmFull.

Parameters:
- ADDR_W, 42, cache-line address width.
- LINES_W, 16, width of line count and line index; the index is carried in mdata.
- MAX_OUTSTANDING, 64, maximum reads in flight (1..2^LINES_W).
- DATA_W, 512, cache-line width.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse that launches a transfer.
- base_addr  in  ADDR_W  cache-line address of line 0; sampled on start.
- num_lines  in  LINES_W  number of lines to read; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when all requested lines have been delivered.
- c0_tx_valid  out  1  read request valid.
- c0_tx_addr  out  ADDR_W  request line address.
- c0_tx_mdata  out  16  request tag; equals the line index zero-extended to 16 bits.
- c0_tx_almfull  in  1  c0TxAlmFull from the FIU.
- c0_rx_valid  in  1  channel-0 response valid.
- c0_rx_is_rdrsp  in  1  response type is read response.
- c0_rx_mdata  in  16  response tag.
- c0_rx_data  in  DATA_W  response data.
- out_valid  out  1  delivered line valid.
- out_idx  out  LINES_W  index of the delivered line.
- out_data  out  DATA_W  delivered line data.

Behaviour:
- Reset (reset==0 at clk edge):
  - Outputs: busy=0, done=0, c0_tx_valid=0, c0_tx_addr=0, c0_tx_mdata=0, out_valid=0, out_idx=0, out_data=0.
  - State: FSM goes to IDLE; issued, received and outstanding counters clear.
  - Reset mid-transfer abandons the transfer. Responses still in flight then arrive in IDLE and are discarded.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr and num_lines and clears the counters.
  - num_lines!=0 -> ISSUE, busy=1 next cycle.
  - num_lines==0 -> DONE directly; no requests issued.
- ISSUE:
  - Issue condition: !c0_tx_almfull && outstanding<MAX_OUTSTANDING && issued<num_lines.
  - When the condition holds, the next cycle has c0_tx_valid=1, c0_tx_addr=base+issued, c0_tx_mdata=issued, and issued increments. This is registered, one request per cycle maximum.
  - Otherwise c0_tx_valid=0 next cycle. Almfull is sampled, so at most one request follows its assertion; this is within the CCI-P slack.
  - Address addition wraps modulo 2^ADDR_W.
  - issued==num_lines after an issue -> DRAIN.
- Response acceptance: any cycle c0_rx_valid && c0_rx_is_rdrsp while busy.
  - Next cycle: out_valid=1, out_idx=c0_rx_mdata[LINES_W-1:0], out_data=c0_rx_data (1-cycle latency).
  - received increments.
  - Responses with is_rdrsp=0 (write acks) are ignored.
- Outstanding counter:
  - +1 on an issue, -1 on an accepted response, unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
  - Accepted responses while IDLE do not touch it.
- DRAIN: when received==num_lines (including the final response's own cycle) -> DONE.
- DONE:
  - done=1 for exactly one cycle, coincident with the last out_valid when num_lines>0.
  - busy=0 in the same cycle; then -> IDLE.
- start while busy or in DONE is ignored.
- out_valid has no backpressure; the consumer must accept every cycle.

Test Plan:
- Basic transfer:
  - Stimulus: reset, start with base=0x1000, num=4, responses in order, 5-cycle latency, almfull=0.
  - Required: requests to addresses 0x1000..0x1003 with mdata 0..3 on 4 consecutive cycles; out_idx 0,1,2,3; done pulses once with the last out_valid; busy low afterward.
- Out-of-order responses:
  - Stimulus: num=4, responses returned as mdata 2,0,3,1.
  - Required: out_idx 2,0,3,1 with data matching each tag; done after the 4th response.
- Credit limit:
  - Stimulus: MAX_OUTSTANDING=8, num=20, responses withheld until 10 cycles after start.
  - Required: exactly 8 requests issued, then c0_tx_valid stays 0; each response releases exactly one further request.
  - Same-cycle issue and response leaves outstanding unchanged.
- Almfull throttle:
  - Stimulus: assert almfull for 6 cycles mid-transfer.
  - Required: at most 1 request in the cycle after assertion, none thereafter until deassertion; issue resumes with the next sequential address, with no gap or duplicate in mdata.
- Zero length and ignored start:
  - Stimulus: num=0.
  - Required: done pulses 1 cycle after start, no c0_tx_valid.
  - Stimulus: start pulsed again while busy.
  - Required: no effect on the running transfer.
- Reset mid-operation:
  - Stimulus: assert reset after 3 of 10 requests are issued, then deliver 3 stale responses in IDLE.
  - Required: all outputs at reset values, no out_valid for the stale responses.
  - A new start with num=2 then completes normally.
